// File: rtl/vga_sched_pkg.sv
// Shared types and VGA vertical timing constants for the frame scheduler.
package vga_sched_pkg;

   localparam int CNT_W  = 10;   // raster counter width
   localparam int STAT_W = 16;   // frame/step statistic counter width

   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 33;
   localparam int V_ACTIVE = 480;

   // Frame ticks a request may stay open before the watchdog drops it
   // (only used when SCHED_TIMEOUT_EN is defined).
   localparam int TIMEOUT_FRAMES = 4;

   // First blanking line (vblank start) and first active line.
   localparam logic [CNT_W-1:0] VB_START  = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [CNT_W-1:0] ACT_START = CNT_W'(V_SYNC + V_BACK);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      REQ  = 2'd2
   } sched_state_t;

   // True on the first pixel of the given line.
   function automatic logic line_start(input logic [CNT_W-1:0] h,
                                       input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] line);
      return (h == '0) && (v == line);
   endfunction

endpackage

// File: rtl/frame_divider.sv
// Divides scheduler frame ticks down to the game-step rate.
// speed_div == 0 behaves like 1 (a step every frame).
module frame_divider
   import vga_sched_pkg::*;
#(
   parameter int DIV_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             advance,
   input  logic [DIV_W-1:0] speed_div,
   output logic             step_due
);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] eff_last;

   // Last count value of a step period; a lowered speed_div that lands
   // below the current count still fires instead of wrapping the counter.
   always_comb begin
      eff_last = (speed_div == '0) ? '0 : speed_div - DIV_W'(1);
      step_due = advance && (div_cnt >= eff_last);
   end

   // Frame counter within the current step period.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (clear || step_due) begin
         div_cnt <= '0;
      end else if (advance) begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Snake game frame scheduler: ticks once per frame at vblank start,
// divides frames to the game-step rate and runs a req/done handshake
// so game state only changes during vertical blanking.
// Optional watchdog: define SCHED_TIMEOUT_EN.
//
// Handshake: upd_req rises one cycle after a due frame_tick and stays
// high until the cycle upd_done is sampled high in REQ; upd_done at any
// other time is ignored, and a held-high upd_done retires one request
// per REQ entry.
module vga_frame_scheduler
   import vga_sched_pkg::*;
#(
   parameter int DIV_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  h_count,
   input  logic [CNT_W-1:0]  v_count,
   input  logic              enable,
   input  logic              pause,
   input  logic [DIV_W-1:0]  speed_div,
   input  logic              upd_done,
   input  logic              clr_overrun,
   output logic              frame_tick,
   output logic              upd_req,
   output logic              busy,
   output logic              overrun,
   output logic              timeout,
   output logic [STAT_W-1:0] frame_cnt,
   output logic [STAT_W-1:0] step_cnt
);

   sched_state_t state;
   logic         vb_hit;
   logic         act_hit;
   logic         div_clear;
   logic         div_advance;
   logic         step_due;

   assign vb_hit      = line_start(h_count, v_count, VB_START);
   assign act_hit     = line_start(h_count, v_count, ACT_START);
   assign div_clear   = (state == IDLE);
   assign div_advance = (state == WAIT) && enable && frame_tick;

   frame_divider #(.DIV_W(DIV_W)) u_frame_divider (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (div_clear),
      .advance   (div_advance),
      .speed_div (speed_div),
      .step_due  (step_due)
   );

   // Per-frame tick at vblank start, counted regardless of scheduler state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_tick <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_tick <= vb_hit;
         if (vb_hit) begin
            frame_cnt <= frame_cnt + STAT_W'(1);
         end
      end
   end

   // Sticky overrun: request still open when active video resumes; set beats clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (upd_req && act_hit) begin
         overrun <= 1'b1;
      end else if (clr_overrun) begin
         overrun <= 1'b0;
      end
   end

`ifdef SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_FRAMES - 1);
   logic [WD_W-1:0] wd_cnt;
`else
   assign timeout = 1'b0;
`endif

   // Scheduler FSM: raise a request on due frames, retire it on upd_done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         upd_req  <= 1'b0;
         busy     <= 1'b0;
         step_cnt <= '0;
`ifdef SCHED_TIMEOUT_EN
         wd_cnt   <= '0;
         timeout  <= 1'b0;
`endif
      end else begin
`ifdef SCHED_TIMEOUT_EN
         if (clr_overrun) begin
            timeout <= 1'b0;
         end
`endif
         case (state)
            IDLE: begin
               if (enable) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (step_due && !pause) begin
                  state   <= REQ;
                  upd_req <= 1'b1;
                  busy    <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
                  wd_cnt  <= '0;
`endif
               end
            end
            REQ: begin
               if (upd_done) begin
                  upd_req  <= 1'b0;
                  busy     <= 1'b0;
                  step_cnt <= step_cnt + STAT_W'(1);
                  state    <= enable ? WAIT : IDLE;
               end
`ifdef SCHED_TIMEOUT_EN
               else if (frame_tick) begin
                  if (wd_cnt == WD_LAST) begin
                     upd_req <= 1'b0;
                     busy    <= 1'b0;
                     timeout <= 1'b1;
                     state   <= WAIT;
                  end else begin
                     wd_cnt <= wd_cnt + WD_W'(1);
                  end
               end
`endif
            end
            default: begin
               state   <= IDLE;
               upd_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
